// File: rtl/disp_owner_arb_pkg.sv
// Shared types and defaults for the seven-segment display owner arbiter.
package disp_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0]  DP_OFF   = 4'b1111;
    localparam logic [15:0] HEX_IDLE = 16'h0000;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DWELL_CYC = 25_000_000;
    localparam int DEF_CNT_W     = 25;

endpackage

// File: rtl/disp_owner_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping, skipping the exclude mask.
module rr_pick
    import disp_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    input  logic [NREQ-1:0] excl,
    output logic            valid,
    output logic [2:0]      idx
);

    logic [NREQ-1:0] cand;

    assign cand = req & ~excl;

    // Walk from the farthest offset down so the nearest hit is the last one written.
    always_comb begin
        automatic int j;
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (cand[j]) begin
                valid = 1'b1;
                idx   = 3'(j);
            end
        end
    end

endmodule

// File: rtl/disp_owner_arb.sv
// Round-robin owner arbiter for the shared 4-digit display, with minimum dwell per grant.
//   state | meaning
//   IDLE  | no owner, display shows idle values
//   OWN   | one requester owns the display, dwell counter running
module disp_owner_arb
    import disp_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DWELL_CYC = DEF_DWELL_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   val,
    input  logic [4*NREQ-1:0]    dp,
    output logic [NREQ-1:0]      grant,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic [3:0]           hex3,
    output logic [3:0]           hex2,
    output logic [3:0]           hex1,
    output logic [3:0]           hex0,
    output logic [3:0]           dp_out
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DWELL_CYC - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [2:0]        ptr, ptr_nx;
    logic [NREQ-1:0]   grant_nx;
    logic [2:0]        owner_nx;
    logic              busy_nx;

    logic              pick_valid;
    logic [2:0]        pick_idx;
    logic [NREQ-1:0]   pick_onehot;
    logic [NREQ-1:0]   excl;
    logic              own_req;
    logic              take;
    logic [15:0]       sel_val;
    logic [3:0]        sel_dp;

    assign excl    = (state == OWN) ? grant : '0;
    assign own_req = |(req & grant);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (excl),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            pick_onehot[i] = (pick_idx == 3'(i));
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        grant_nx = grant;
        owner_nx = owner;
        busy_nx  = busy;
        take     = 1'b0;
        case (state)
            IDLE: begin
                take = pick_valid;
            end
            OWN: begin
                if (!own_req) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        owner_nx = '0;
                        busy_nx  = 1'b0;
                        cnt_nx   = '0;
                    end
                end else if (cnt == CNT_TC) begin
                    take = pick_valid;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (take) begin
            state_nx = OWN;
            grant_nx = pick_onehot;
            owner_nx = pick_idx;
            busy_nx  = 1'b1;
            cnt_nx   = '0;
            ptr_nx   = (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
        end
    end

    // Owner's slice is sampled every cycle so live value changes reach the display.
    always_comb begin
        sel_val = '0;
        sel_dp  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_val = sel_val | val[16*i +: 16];
                sel_dp  = sel_dp  | dp[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= '0;
            grant  <= '0;
            owner  <= '0;
            busy   <= 1'b0;
            {hex3, hex2, hex1, hex0} <= HEX_IDLE;
            dp_out <= DP_OFF;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ptr    <= ptr_nx;
            grant  <= grant_nx;
            owner  <= owner_nx;
            busy   <= busy_nx;
            {hex3, hex2, hex1, hex0} <= busy ? sel_val : HEX_IDLE;
            dp_out <= busy ? sel_dp : DP_OFF;
        end
    end

endmodule

// File: tb/tb_disp_owner_arb.sv
// Self-checking bench for disp_owner_arb: directed scenarios plus randomized run against a reference model.
module tb_disp_owner_arb;

    localparam int N     = 4;
    localparam int DWELL = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [16*N-1:0] val;
    logic [4*N-1:0]  dp;
    logic [N-1:0]    grant;
    logic [2:0]      owner;
    logic            busy;
    logic [3:0]      hex3, hex2, hex1, hex0, dp_out;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: who owns the display, how long it has held it, where the search starts.
    int          m_busy, m_owner, m_held, m_ptr;
    logic [15:0] m_hex;
    logic [3:0]  m_dp;

    disp_owner_arb #(.NREQ(N), .DWELL_CYC(DWELL), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .val    (val),
        .dp     (dp),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy),
        .hex3   (hex3),
        .hex2   (hex2),
        .hex1   (hex1),
        .hex0   (hex0),
        .dp_out (dp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [N-1:0] r, int start, int skip);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        return m_busy ? (N'(1) << m_owner) : '0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0;
        m_hex = 16'h0000; m_dp = 4'b1111;
    endtask

    task automatic model_step();
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_busy != 0) begin
            m_hex = val[16*m_owner +: 16];
            m_dp  = dp[4*m_owner +: 4];
        end else begin
            m_hex = 16'h0000;
            m_dp  = 4'b1111;
        end
        w = -1;
        if (m_busy == 0) begin
            w = pick(req, m_ptr, -1);
        end else if (!req[m_owner]) begin
            w = pick(req, m_ptr, m_owner);
            if (w < 0) begin
                m_busy = 0; m_owner = 0; m_held = 0;
            end
        end else if (m_held >= DWELL - 1) begin
            w = pick(req, m_ptr, m_owner);
            if (w < 0) m_held++;
        end else begin
            m_held++;
        end
        if (w >= 0) begin
            m_busy = 1; m_owner = w; m_held = 0; m_ptr = (w + 1) % N;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req = '0; val = '0; dp = '1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; val = '0; dp = '1;
        #2;
        model_reset();
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 3'd0) begin
            failed++;
            $display("FAIL reset_ctrl: grant=%b busy=%b owner=%0d, required 0000/0/0", grant, busy, owner);
        end
        tests_run++;
        if ({hex3, hex2, hex1, hex0} !== 16'h0000 || dp_out !== 4'b1111) begin
            failed++;
            $display("FAIL reset_disp: hex=%h dp_out=%b, required 0000/1111", {hex3, hex2, hex1, hex0}, dp_out);
        end
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_first_grant();
        do_reset();
        req = 4'b1010;
        val[16 +: 16] = 16'h1234;
        cycle();
        tests_run++;
        if (grant !== 4'b0010 || owner !== 3'd1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL first_grant: grant=%b owner=%0d busy=%b, required 0010/1/1", grant, owner, busy);
        end
        tests_run++;
        if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin
            failed++;
            $display("FAIL first_grant_lag: hex=%h, required 0000", {hex3, hex2, hex1, hex0});
        end
        cycle();
        tests_run++;
        if (hex3 !== 4'd1 || hex2 !== 4'd2 || hex1 !== 4'd3 || hex0 !== 4'd4) begin
            failed++;
            $display("FAIL first_grant_data: hex=%h, required 1234", {hex3, hex2, hex1, hex0});
        end
    endtask

    task automatic test_dwell();
        int last_change, changes;
        logic [N-1:0] prev;
        do_reset();
        req = 4'b0011;
        cycle();
        tests_run++;
        if (grant !== 4'b0001) begin
            failed++;
            $display("FAIL dwell_start: grant=%b, required 0001", grant);
        end
        prev = grant; last_change = 0; changes = 0;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            tests_run++;
            if (grant !== m_grant()) begin
                failed++;
                $display("FAIL dwell_grant: cycle %0d grant=%b, required %b", c, grant, m_grant());
            end
            if (grant !== prev) begin
                changes++;
                tests_run++;
                if (c - last_change != DWELL) begin
                    failed++;
                    $display("FAIL dwell_interval: held %0d cycles, required %0d", c - last_change, DWELL);
                end
                last_change = c;
                prev = grant;
            end
        end
        tests_run++;
        if (changes != 5) begin
            failed++;
            $display("FAIL dwell_count: %0d switches, required 5", changes);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b0001;
        repeat (21) cycle();
        tests_run++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            failed++;
            $display("FAIL sat_hold: grant=%b busy=%b, required 0001/1", grant, busy);
        end
        req = 4'b0101;
        cycle();
        tests_run++;
        if (grant !== 4'b0100 || owner !== 3'd2) begin
            failed++;
            $display("FAIL sat_switch: grant=%b owner=%0d, required 0100/2", grant, owner);
        end
    endtask

    task automatic test_release();
        do_reset();
        dp[3:0] = 4'b0101;
        req = 4'b0100;
        repeat (3) cycle();
        req = 4'b0001;
        cycle();
        tests_run++;
        if (grant !== 4'b0001 || busy !== 1'b1 || owner !== 3'd0) begin
            failed++;
            $display("FAIL release_handoff: grant=%b busy=%b owner=%0d, required 0001/1/0", grant, busy, owner);
        end
        cycle();
        tests_run++;
        if (dp_out !== 4'b0101) begin
            failed++;
            $display("FAIL release_newdata: dp_out=%b, required 0101", dp_out);
        end
        req = 4'b0000;
        cycle();
        tests_run++;
        if (busy !== 1'b0 || grant !== 4'b0000 || dp_out !== 4'b0101) begin
            failed++;
            $display("FAIL release_idle: busy=%b grant=%b dp_out=%b, required 0/0000/0101", busy, grant, dp_out);
        end
        cycle();
        tests_run++;
        if (dp_out !== 4'b1111 || {hex3, hex2, hex1, hex0} !== 16'h0000) begin
            failed++;
            $display("FAIL release_blank: dp_out=%b hex=%h, required 1111/0000", dp_out, {hex3, hex2, hex1, hex0});
        end
    endtask

    task automatic test_live_val();
        do_reset();
        req = 4'b0100;
        val[32 +: 16] = 16'hABCD;
        repeat (2) cycle();
        tests_run++;
        if ({hex3, hex2, hex1, hex0} !== 16'hABCD) begin
            failed++;
            $display("FAIL live_first: hex=%h, required abcd", {hex3, hex2, hex1, hex0});
        end
        val[32 +: 16] = 16'h0F00;
        cycle();
        tests_run++;
        if ({hex3, hex2, hex1, hex0} !== 16'h0F00 || grant !== 4'b0100) begin
            failed++;
            $display("FAIL live_update: hex=%h grant=%b, required 0f00/0100", {hex3, hex2, hex1, hex0}, grant);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        val[32 +: 16] = 16'h5A5A;
        dp[11:8] = 4'b0011;
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0 || {hex3, hex2, hex1, hex0} !== 16'h0000 || dp_out !== 4'b1111) begin
            failed++;
            $display("FAIL midreset_async: grant=%b busy=%b hex=%h dp_out=%b, required 0000/0/0000/1111", grant, busy, {hex3, hex2, hex1, hex0}, dp_out);
        end
        cycle();
        reset = 1'b0;
        #1;
        tests_run++;
        if (grant !== 4'b0000) begin
            failed++;
            $display("FAIL midreset_hold: grant=%b, required 0000", grant);
        end
        cycle();
        tests_run++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            failed++;
            $display("FAIL midreset_regrant: grant=%b busy=%b, required 0100/1", grant, busy);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 1) == 0) val = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) dp = 16'($urandom);
            cycle();
            tests_run++;
            if (grant !== m_grant() || busy !== (m_busy != 0) || owner !== 3'(m_owner)) begin
                failed++;
                $display("FAIL rand_ctrl: cycle %0d grant=%b owner=%0d busy=%b, required %b/%0d/%0d", c, grant, owner, busy, m_grant(), m_owner, m_busy);
            end
            tests_run++;
            if ({hex3, hex2, hex1, hex0} !== m_hex || dp_out !== m_dp) begin
                failed++;
                $display("FAIL rand_disp: cycle %0d hex=%h dp_out=%b, required %h/%b", c, {hex3, hex2, hex1, hex0}, dp_out, m_hex, m_dp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; val = '0; dp = '1;
        model_reset();
        test_reset();
        test_first_grant();
        test_dwell();
        test_saturate();
        test_release();
        test_live_val();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
